// File: rtl/dbr_pkg.sv
// Shared constants and helpers for the V810 data bus resizer.
// Holds the device-width codes, the default wait-counter width and the
// lane-select rule used when a 16-bit device answers a read.
package dbr_pkg;

    localparam int DW_16         = 16;
    localparam int DW_32         = 32;
    localparam int CNT_W_DEFAULT = 8;

    // A 16-bit device answers the upper half when the controller has
    // disabled both lower byte lanes (active-low enables).
    function automatic logic hi_half(input logic [3:0] be_n);
        return (be_n[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/dbr_wait_counter.sv
// Wait-state counter for one emulated memory device.
// Counts CE-qualified clocks of the current data phase and flags "ready"
// once the count reaches the programmed wait states; saturates at the
// largest value the counter can hold so oversized WS values still complete.
module dbr_wait_counter
    import dbr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        active,
    input  logic [31:0] ws,
    output logic        ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ws_sat;

    // Clamp the requested wait states to what the counter can reach.
    always_comb begin
        ws_sat = ws[CNT_W-1:0];
        if (ws > 32'(CNT_MAX)) begin
            ws_sat = CNT_MAX;
        end
    end

    // Ready is combinational so the cycle completes in the same clock the count matches.
    always_comb begin
        ready = active && (cnt == ws_sat);
    end

    // Count data-phase clocks; restart whenever the device is idle or a cycle completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ce) begin
            if (!active || ready) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/v810_data_bus_resizer.sv
// V810 external-bus device model sitting in front of a 32-bit synchronous RAM.
// Emulates a 16- or 32-bit device with programmable wait states, drives the
// active-low READYn/SZRQn handshake and steers byte lanes between the
// controller and the RAM. Idle outputs are high so several instances can
// share the active-low handshake lines.
// Optional build macro: DBR_CHECK_EN enables simulation-only protocol checks.
//
// Handshake: a bus cycle is "active" while CTLR_DAn and MEM_nCE are low and
// reset is released. The cycle completes on the clock edge (with CE=1) at
// which CTLR_READYn is low; CTLR_SZRQn is low alongside it on every cycle of
// a 16-bit device, telling the controller that only 16 bits were transferred.
module v810_data_bus_resizer
    import dbr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [31:0] WS,
    input  logic [31:0] DW,
    input  logic        CTLR_DAn,
    input  logic [3:0]  CTLR_BEn,
    output logic        CTLR_READYn,
    output logic        CTLR_SZRQn,
    output logic [31:0] CTLR_DI,
    input  logic [31:0] CTLR_DO,
    input  logic        MEM_nCE,
    output logic [31:0] MEM_DI,
    input  logic [31:0] MEM_DO
);

    logic active;
    logic ready;
    logic dw_is_16;

    assign active   = ~CTLR_DAn & ~MEM_nCE & RESn;
    assign dw_is_16 = (DW == DW_16);

    dbr_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk    (CLK),
        .rst_n  (RESn),
        .ce     (CE),
        .active (active),
        .ws     (WS),
        .ready  (ready)
    );

    // Active-low handshake; both lines rest high whenever the device is idle.
    always_comb begin
        CTLR_READYn = ~ready;
        CTLR_SZRQn  = ~(active & dw_is_16);
    end

    // Byte-lane steering: 32-bit devices pass straight through, 16-bit devices
    // map the selected RAM half onto D[15:0] and replicate write data.
    always_comb begin
        CTLR_DI = MEM_DO;
        MEM_DI  = CTLR_DO;
        if (dw_is_16) begin
            CTLR_DI[31:16] = MEM_DO[31:16];
            CTLR_DI[15:0]  = hi_half(CTLR_BEn) ? MEM_DO[31:16] : MEM_DO[15:0];
            MEM_DI         = {CTLR_DO[15:0], CTLR_DO[15:0]};
        end
    end

`ifdef DBR_CHECK_EN
    logic        chk_active_q;
    logic        chk_split_q;
    logic [31:0] chk_ws_q;

    // Track the previous clock's activity, WS and whether a split word is pending.
    always @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            chk_active_q <= 1'b0;
            chk_split_q  <= 1'b0;
            chk_ws_q     <= '0;
        end else if (CE) begin
            chk_active_q <= active;
            chk_ws_q     <= WS;
            if (!active) begin
                chk_split_q <= 1'b0;
            end else if (ready) begin
                chk_split_q <= dw_is_16 && !chk_split_q &&
                               (CTLR_BEn[1:0] != 2'b11) && (CTLR_BEn[3:2] != 2'b11);
            end
        end
    end

    // Protocol checks on every CE-qualified edge.
    always @(posedge CLK) begin
        if (RESn && CE) begin
            if ((DW != DW_16) && (DW != DW_32)) begin
                $error("dbr: unsupported device width %0d", DW);
            end
            if (active && (CTLR_BEn == 4'hF)) begin
                $error("dbr: active cycle with no byte lane enabled");
            end
            if (active && dw_is_16 && chk_split_q &&
                (CTLR_BEn[1:0] != 2'b11) && (CTLR_BEn[3:2] != 2'b11)) begin
                $error("dbr: both halves enabled on reissued 16-bit beat");
            end
            if (active && chk_active_q && (WS != chk_ws_q)) begin
                $error("dbr: WS changed during an active cycle");
            end
        end
    end
`endif

endmodule

// File: tb/tb_v810_data_bus_resizer.sv
// Self-checking bench for v810_data_bus_resizer: directed scenarios with
// hand-computed expectations plus a randomized phase, all compared every
// cycle against a behavioural model of the bus device.
module tb_v810_data_bus_resizer;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESn;
    logic        CE;
    logic [31:0] WS;
    logic [31:0] DW;
    logic        DAn;
    logic [3:0]  BEn;
    logic [31:0] CTLR_DO;
    logic [31:0] MEM_DO;
    logic        nce0;
    logic        nce1;

    logic        r0, s0, r1, s1;
    logic [31:0] di0, mdi0, di1, mdi1;

    v810_data_bus_resizer dut (
        .CLK         (CLK),
        .RESn        (RESn),
        .CE          (CE),
        .WS          (WS),
        .DW          (DW),
        .CTLR_DAn    (DAn),
        .CTLR_BEn    (BEn),
        .CTLR_READYn (r0),
        .CTLR_SZRQn  (s0),
        .CTLR_DI     (di0),
        .CTLR_DO     (CTLR_DO),
        .MEM_nCE     (nce0),
        .MEM_DI      (mdi0),
        .MEM_DO      (MEM_DO)
    );

    // Second device on the same bus; normally deselected.
    v810_data_bus_resizer dut_b (
        .CLK         (CLK),
        .RESn        (RESn),
        .CE          (CE),
        .WS          (WS),
        .DW          (DW),
        .CTLR_DAn    (DAn),
        .CTLR_BEn    (BEn),
        .CTLR_READYn (r1),
        .CTLR_SZRQn  (s1),
        .CTLR_DI     (di1),
        .CTLR_DO     (CTLR_DO),
        .MEM_nCE     (nce1),
        .MEM_DI      (mdi1),
        .MEM_DO      (MEM_DO)
    );

    // Active-low lines from several devices combine by AND: an idle device drives 1.
    logic bus_readyn, bus_szrqn;
    assign bus_readyn = r0 & r1;
    assign bus_szrqn  = s0 & s1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // elapsed = CE-qualified clocks already spent in the current access.
    int elapsed = 0;

    function automatic int ws_limit(input logic [31:0] ws);
        return (ws > 32'd255) ? 255 : int'(ws);
    endfunction

    function automatic logic m_active();
        return !DAn && !nce0 && RESn;
    endfunction

    function automatic logic m_ready();
        return m_active() && (elapsed == ws_limit(WS));
    endfunction

    always @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            elapsed = 0;
        end else if (CE) begin
            if (!m_active() || m_ready()) elapsed = 0;
            else elapsed = elapsed + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        logic [31:0] e_di, e_mdi;
        logic        wide;
        wide  = (DW != 32'd16);
        e_di  = MEM_DO;
        e_mdi = CTLR_DO;
        if (!wide) begin
            e_di  = {MEM_DO[31:16], (BEn[1:0] == 2'b11) ? MEM_DO[31:16] : MEM_DO[15:0]};
            e_mdi = {CTLR_DO[15:0], CTLR_DO[15:0]};
        end
        check("model_readyn", 32'(r0), 32'(!m_ready()));
        check("model_szrqn",  32'(s0), 32'(!(m_active() && !wide)));
        check("model_ctlr_di", di0, e_di);
        check("model_mem_di",  mdi0, e_mdi);
        if (nce1) begin
            check("model_bus_readyn", 32'(bus_readyn), 32'(!m_ready()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic go_idle();
        DAn = 1'b1;
        CE  = 1'b1;
        BEn = 4'hF;
        step();
    endtask

    // Timeout guard.
    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [31:0] ram;

    initial begin
        RESn = 1'b0; CE = 1'b1; WS = 0; DW = 32; DAn = 1'b1; BEn = 4'hF;
        CTLR_DO = 0; MEM_DO = 0; nce0 = 1'b1; nce1 = 1'b1;
        @(negedge CLK);
        check("reset_readyn", 32'(r0), 32'd1);
        check("reset_szrqn",  32'(s0), 32'd1);
        step();
        RESn = 1'b1;
        step();

        // 1: 32-bit, no waits
        nce0 = 1'b0; DW = 32; WS = 0; BEn = 4'h0; DAn = 1'b0; MEM_DO = 32'h12345678;
        @(negedge CLK);
        check("t1_readyn", 32'(r0), 32'd0);
        check("t1_szrqn",  32'(s0), 32'd1);
        check("t1_di",     di0, 32'h12345678);
        go_idle();

        // 2: 32-bit, one wait, back-to-back restart
        WS = 1; BEn = 4'h0; DAn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t2_readyn", 32'(r0), (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end
        go_idle();

        // 3: 16-bit word read split into two halves
        DW = 16; WS = 0; MEM_DO = 32'hAABBCCDD; BEn = 4'b0000; DAn = 1'b0;
        @(negedge CLK);
        check("t3a_readyn", 32'(r0), 32'd0);
        check("t3a_szrqn",  32'(s0), 32'd0);
        check("t3a_di",     di0, 32'hAABBCCDD);
        step();
        BEn = 4'b0011;
        @(negedge CLK);
        check("t3b_di",     di0, 32'hAABBAABB);
        check("t3b_readyn", 32'(r0), 32'd0);
        go_idle();

        // 4: 16-bit halfword write to upper lanes
        ram = 32'h11223344;
        BEn = 4'b0011; CTLR_DO = 32'h00005A5A; DAn = 1'b0;
        @(negedge CLK);
        check("t4_mem_di", mdi0, 32'h5A5A5A5A);
        for (int l = 0; l < 4; l++) begin
            if (!BEn[l] && !r0) ram[8*l +: 8] = mdi0[8*l +: 8];
        end
        check("t4_ram", ram, 32'h5A5A3344);
        go_idle();

        // 5: deselected device, then reset mid-cycle
        nce0 = 1'b1; DAn = 1'b0; BEn = 4'h0; WS = 0;
        @(negedge CLK);
        check("t5_nce_readyn", 32'(r0), 32'd1);
        check("t5_nce_szrqn",  32'(s0), 32'd1);
        go_idle();
        nce0 = 1'b0; WS = 5; BEn = 4'h0; DAn = 1'b0;
        step(); step();
        RESn = 1'b0;
        @(negedge CLK);
        check("t5_rst_readyn", 32'(r0), 32'd1);
        check("t5_rst_szrqn",  32'(s0), 32'd1);
        step();
        RESn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("t5_restart", 32'(r0), (i == 5) ? 32'd0 : 32'd1);
            step();
        end
        go_idle();

        // 6: shared bus, only the second device selected
        nce0 = 1'b1; nce1 = 1'b0; WS = 0; DW = 16; BEn = 4'h0; DAn = 1'b0;
        @(negedge CLK);
        check("t6_bus_readyn", 32'(bus_readyn), 32'd0);
        check("t6_bus_szrqn",  32'(bus_szrqn),  32'd0);
        check("t6_dev0_readyn", 32'(r0), 32'd1);
        step();
        DW = 32;
        @(negedge CLK);
        check("t6_bus_szrqn32", 32'(bus_szrqn), 32'd1);
        go_idle();
        nce1 = 1'b1; nce0 = 1'b0;
        go_idle();

        // Saturation: WS beyond counter range completes after 255 waits
        WS = 300; DW = 32; BEn = 4'h0; DAn = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (i == 254) check("sat_wait", 32'(r0), 32'd1);
            if (i == 255) check("sat_ready", 32'(r0), 32'd0);
            step();
        end
        go_idle();

        // Randomized phase
        for (int t = 0; t < 300; t++) begin
            go_idle();
            case ($urandom_range(0, 4))
                0: WS = 0;
                1: WS = 1;
                2: WS = 2;
                3: WS = 7;
                default: WS = 32'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 2))
                0: DW = 16;
                1: DW = 32;
                default: DW = 24;
            endcase
            for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
                CE      = ($urandom_range(0, 3) != 0);
                DAn     = ($urandom_range(0, 7) == 0);
                nce0    = ($urandom_range(0, 9) == 0);
                BEn     = 4'($urandom_range(0, 14));
                CTLR_DO = $urandom;
                MEM_DO  = $urandom;
                RESn    = ($urandom_range(0, 60) != 0);
                step();
                RESn    = 1'b1;
            end
        end
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
